// File: rtl/serial_mem_responder_if.sv
// UART byte stream and 32-bit memory bus bundle for serial_mem_responder.
// master is the responder side, slave is the UART/memory side.
interface serial_mem_responder_if;
    logic [7:0]  RX;
    logic        hasRX;
    logic [7:0]  TX;
    logic        start_TX;
    logic        TX_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        protoError;

    modport master (
        input  RX, hasRX, TX_ready, mem_rdata, mem_ack,
        output TX, start_TX, mem_req, mem_we, mem_addr, mem_wdata,
        output busy, protoError
    );

    modport slave (
        output RX, hasRX, TX_ready, mem_rdata, mem_ack,
        input  TX, start_TX, mem_req, mem_we, mem_addr, mem_wdata,
        input  busy, protoError
    );
endinterface

// File: rtl/serial_mem_responder.sv
// Host-link command responder: parses checksummed read/write packets from
// the UART, performs one memory access per packet and sends the reply.
module serial_mem_responder #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000
) (
    input  logic clk,
    input  logic rst,
    serial_mem_responder_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, GET_SUM, MEM, SEND, SEND_WAIT
    } state_t;

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  sum_q, sum_d;
    logic [39:0] reply_q, reply_d;
    logic [2:0]  left_q, left_d;
    logic [31:0] tmo_q, tmo_d;
    logic        req_q, req_d;
    logic        perr_q, perr_d;
    logic        fresh_q;
    logic        start_tx;
    logic        tmo_hit;

    assign tmo_hit = (tmo_q >= TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        state_d  = state_q;
        is_wr_d  = is_wr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sum_d    = sum_q;
        reply_d  = reply_q;
        left_d   = left_q;
        tmo_d    = '0;
        req_d    = req_q;
        perr_d   = 1'b0;
        start_tx = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.hasRX) begin
                    if (bus.RX == OP_WR || bus.RX == OP_RD) begin
                        is_wr_d = (bus.RX == OP_WR);
                        sum_d   = bus.RX;
                        cnt_d   = 2'd0;
                        state_d = GET_ADDR;
                    end else begin
                        reply_d = {NAK, 32'h0};
                        left_d  = 3'd1;
                        state_d = SEND;
                    end
                end
            end
            GET_ADDR: begin
                tmo_d = tmo_q + 32'd1;
                if (bus.hasRX) begin
                    tmo_d  = '0;
                    addr_d = {addr_q[23:0], bus.RX};
                    sum_d  = sum_q + bus.RX;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = is_wr_q ? GET_DATA : GET_SUM;
                end else if (tmo_hit) begin
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                tmo_d = tmo_q + 32'd1;
                if (bus.hasRX) begin
                    tmo_d   = '0;
                    wdata_d = {wdata_q[23:0], bus.RX};
                    sum_d   = sum_q + bus.RX;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = GET_SUM;
                end else if (tmo_hit) begin
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_SUM: begin
                tmo_d = tmo_q + 32'd1;
                if (bus.hasRX) begin
                    tmo_d = '0;
                    if (bus.RX == sum_q) begin
                        req_d   = 1'b1;
                        state_d = MEM;
                    end else begin
                        reply_d = {NAK, 32'h0};
                        left_d  = 3'd1;
                        state_d = SEND;
                    end
                end else if (tmo_hit) begin
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            MEM: begin
                perr_d = bus.hasRX;
                if (bus.mem_ack && req_q) begin
                    req_d   = 1'b0;
                    reply_d = is_wr_q ? {ACK, 32'h0} : {ACK, bus.mem_rdata};
                    left_d  = is_wr_q ? 3'd1 : 3'd5;
                    state_d = SEND;
                end
            end
            SEND: begin
                perr_d = bus.hasRX;
                // first SEND cycle never issues, so TX has settled
                if (!fresh_q && bus.TX_ready) begin
                    start_tx = 1'b1;
                    state_d  = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                perr_d = bus.hasRX;
                // skip the cycle right after start_TX: TX_ready drops late
                if (!fresh_q && bus.TX_ready) begin
                    reply_d = {reply_q[31:0], 8'h00};
                    left_d  = left_q - 3'd1;
                    state_d = (left_q == 3'd1) ? IDLE : SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            is_wr_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sum_q   <= '0;
            reply_q <= '0;
            left_q  <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            perr_q  <= 1'b0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sum_q   <= sum_d;
            reply_q <= reply_d;
            left_q  <= left_d;
            tmo_q   <= tmo_d;
            req_q   <= req_d;
            perr_q  <= perr_d;
            fresh_q <= (state_d != state_q);
        end
    end

    assign bus.TX         = reply_q[39:32];
    assign bus.start_TX   = start_tx;
    assign bus.mem_req    = req_q;
    assign bus.mem_we     = is_wr_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.protoError = perr_q;
endmodule

// File: tb/tb_serial_mem_responder.sv
// Bench for serial_mem_responder: UART and memory models with scoreboard
// queues for transmitted bytes and memory requests.
module tb_serial_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_mem_responder_if bus();

    serial_mem_responder #(.TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_tx[$];
    logic [64:0] exp_mem[$];
    logic [7:0]  pkt[$];
    int n_start = 0;
    int n_req   = 0;
    int n_perr  = 0;

    bit hold_low = 1'b0;
    int ucnt = 0;
    logic [31:0] rdata_val = 32'h0;
    int ack_delay = 3;
    int stray_req = 0;
    int stray_done = 0;

    // UART: TX_ready drops one cycle late and stays low for three cycles
    assign bus.TX_ready = !hold_low && (ucnt == 0 || ucnt == 4);

    always @(posedge clk) begin
        if (bus.start_TX && bus.TX_ready) ucnt <= 4;
        else if (ucnt > 0) ucnt <= ucnt - 1;
    end

    logic [7:0] tx_e;
    always @(negedge clk) begin
        if (bus.protoError) n_perr++;
        if (bus.start_TX) begin
            n_start++;
            tests++;
            if (bus.TX_ready !== 1'b1) begin
                fails++;
                $display("FAIL start_when_ready: TX_ready=%b required 1", bus.TX_ready);
            end
            tests++;
            if (exp_tx.size() == 0) begin
                fails++;
                $display("FAIL tx_extra: TX=%h required no byte", bus.TX);
            end else begin
                tx_e = exp_tx.pop_front();
                if (bus.TX !== tx_e) begin
                    fails++;
                    $display("FAIL tx_byte: TX=%h required %h", bus.TX, tx_e);
                end
            end
        end
    end

    // memory: one ack after ack_delay cycles of mem_req
    bit m_active = 1'b0;
    int m_dly = 0;
    logic [64:0] m_cur, m_exp, m_obs;
    always @(negedge clk) begin
        m_obs = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
        if (!rst) begin
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 32'h0;
            m_active = 1'b0;
        end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
        end else if (stray_req != stray_done && !bus.mem_req) begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = 32'hFFFF_FFFF;
            stray_done++;
        end else if (bus.mem_req) begin
            tests++;
            if (!m_active) begin
                m_active = 1'b1;
                m_dly = 0;
                m_cur = m_obs;
                n_req++;
                if (exp_mem.size() == 0) begin
                    fails++;
                    $display("FAIL mem_extra: req=%h required no request", m_obs);
                end else begin
                    m_exp = exp_mem.pop_front();
                    if (!m_exp[64]) begin
                        m_exp[31:0] = 32'h0;
                        m_obs[31:0] = 32'h0;
                    end
                    if (m_obs !== m_exp) begin
                        fails++;
                        $display("FAIL mem_req_fields: got %h required %h", m_obs, m_exp);
                    end
                end
            end else if (m_obs !== m_cur) begin
                fails++;
                $display("FAIL mem_stable: got %h required %h", m_obs, m_cur);
            end
            m_dly++;
            if (m_dly >= ack_delay) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = rdata_val;
                m_active = 1'b0;
            end
        end
    end

    task automatic send_pkt();
        foreach (pkt[i]) begin
            @(negedge clk);
            bus.RX = pkt[i];
            bus.hasRX = 1'b1;
        end
        @(negedge clk);
        bus.hasRX = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((bus.busy || exp_tx.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 2000 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: busy=%b pending=%0d required idle", nm, bus.busy, exp_tx.size());
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] s;
        s = 8'h52 + a[31:24] + a[23:16] + a[15:8] + a[7:0];
        rdata_val = d;
        exp_mem.push_back({1'b0, a, 32'h0});
        exp_tx.push_back(8'h06);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
        pkt = '{8'h52, a[31:24], a[23:16], a[15:8], a[7:0], s};
        send_pkt();
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({bus.TX, bus.start_TX, bus.mem_req, bus.mem_we, bus.mem_addr,
             bus.mem_wdata, bus.busy, bus.protoError} !== 76'h0) begin
            fails++;
            $display("FAIL reset_values: TX=%h req=%b busy=%b required all zero",
                     bus.TX, bus.mem_req, bus.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int s0 = n_start;
        int r0 = n_req;
        ack_delay = 3;
        exp_mem.push_back({1'b1, 32'h10, 32'hDEADBEEF});
        exp_tx.push_back(8'h06);
        pkt = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h9F};
        send_pkt();
        tests++;
        if (bus.mem_req !== 1'b1) begin
            fails++;
            $display("FAIL write_req_rise: mem_req=%b required 1", bus.mem_req);
        end
        wait_done("write");
        tests++;
        if (n_start - s0 != 1 || n_req - r0 != 1) begin
            fails++;
            $display("FAIL write_counts: starts=%0d reqs=%0d required 1 1", n_start - s0, n_req - r0);
        end
    endtask

    task automatic test_read();
        int s0 = n_start;
        do_read(32'h10, 32'hCAFEF00D);
        wait_done("read");
        tests++;
        if (n_start - s0 != 5) begin
            fails++;
            $display("FAIL read_starts: got %0d required 5", n_start - s0);
        end
    endtask

    task automatic test_bad_sum();
        int r0 = n_req;
        exp_tx.push_back(8'h15);
        pkt = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        send_pkt();
        wait_done("badsum");
        tests++;
        if (n_req != r0) begin
            fails++;
            $display("FAIL badsum_no_req: reqs=%0d required 0", n_req - r0);
        end
    endtask

    task automatic test_unknown_op();
        int s0 = n_start;
        exp_tx.push_back(8'h15);
        pkt = '{8'h41};
        send_pkt();
        wait_done("unknown");
        tests++;
        if (n_start - s0 != 1) begin
            fails++;
            $display("FAIL unknown_starts: got %0d required 1", n_start - s0);
        end
        ack_delay = 1;
        do_read(32'h0000_0ABC, 32'h12345678);
        wait_done("after_unknown");
    endtask

    task automatic test_stray_ack();
        int s0 = n_start;
        stray_req++;
        repeat (4) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || n_start != s0) begin
            fails++;
            $display("FAIL stray_ack: busy=%b req=%b starts=%0d required 0 0 0",
                     bus.busy, bus.mem_req, n_start - s0);
        end
    endtask

    task automatic test_timeout();
        int s0 = n_start;
        int p0 = n_perr;
        int n = 0;
        pkt = '{8'h52, 8'h00};
        send_pkt();
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.protoError) break;
        end
        tests++;
        if (n != 100) begin
            fails++;
            $display("FAIL timeout_cycles: got %0d required 100", n);
        end
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_busy: busy=%b required 0", bus.busy);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (n_perr - p0 != 1 || n_start != s0) begin
            fails++;
            $display("FAIL timeout_pulse: pulses=%0d starts=%0d required 1 0",
                     n_perr - p0, n_start - s0);
        end
        ack_delay = 2;
        do_read(32'h8000_0004, 32'h0BADF00D);
        wait_done("after_timeout");
    endtask

    task automatic test_drop();
        int p0 = n_perr;
        ack_delay = 8;
        do_read(32'h44, 32'h5566_7788);
        @(negedge clk);
        bus.RX = 8'h99;
        bus.hasRX = 1'b1;
        @(negedge clk);
        bus.hasRX = 1'b0;
        wait_done("drop");
        tests++;
        if (n_perr - p0 != 1) begin
            fails++;
            $display("FAIL drop_pulse: got %0d required 1", n_perr - p0);
        end
    endtask

    task automatic test_backpressure_reset();
        int s0 = n_start;
        int s1;
        int n = 0;
        ack_delay = 1;
        do_read(32'h20, 32'hA5A55A5A);
        while (n_start - s0 < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        hold_low = 1'b1;
        s1 = n_start;
        repeat (50) @(posedge clk);
        #1;
        tests++;
        if (n_start != s1) begin
            fails++;
            $display("FAIL backpressure: starts=%0d required 0", n_start - s1);
        end
        hold_low = 1'b0;
        wait_done("backpressure");
        tests++;
        if (n_start - s0 != 5) begin
            fails++;
            $display("FAIL bp_starts: got %0d required 5", n_start - s0);
        end
        s0 = n_start;
        do_read(32'h24, 32'h01020304);
        n = 0;
        while (n_start - s0 < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #3;
        rst = 1'b0;
        #1;
        tests++;
        if ({bus.TX, bus.start_TX, bus.mem_req, bus.mem_we, bus.mem_addr,
             bus.mem_wdata, bus.busy, bus.protoError} !== 76'h0) begin
            fails++;
            $display("FAIL midreply_reset: TX=%h req=%b busy=%b required all zero",
                     bus.TX, bus.mem_req, bus.busy);
        end
        exp_tx.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_mem.push_back({1'b1, 32'h20, 32'h11223344});
        exp_tx.push_back(8'h06);
        pkt = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44, 8'h21};
        send_pkt();
        wait_done("after_reset");
    endtask

    initial begin
        bus.RX = 8'h00;
        bus.hasRX = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_bad_sum();
        test_unknown_op();
        test_stray_ack();
        test_timeout();
        test_drop();
        test_backpressure_reset();
        repeat (5) @(negedge clk);
        tests++;
        if (exp_tx.size() != 0 || exp_mem.size() != 0) begin
            fails++;
            $display("FAIL leftover: tx=%0d mem=%0d required 0 0", exp_tx.size(), exp_mem.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
